// File: rtl/execute_md.sv
// EX stage: single-cycle ALU path plus iterative multiply/divide with HI/LO.
// Latency: ALU/MF*/MT* results registered 1 cycle after accept; MD ops keep md_busy for WIDTH+1 cycles.
// Backpressure: stall_mem freezes ex_mem; MD-class ops arriving while md_busy hold upstream via stall_ex.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] shamt;
    assign shamt = a[SH_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            4'd0:  y = a + b;
            4'd1:  y = a - b;
            4'd2:  y = a & b;
            4'd3:  y = a | b;
            4'd4:  y = a ^ b;
            4'd5:  y = ~(a | b);
            4'd6:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd7:  y = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd8:  y = b << shamt;
            4'd9:  y = b >> shamt;
            4'd10: y = $signed(b) >>> shamt;
            4'd11: y = b << (WIDTH/2);
            default: y = '0;
        endcase
    end
endmodule

module execute_md #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_id_ex,
    input  logic [3:0]        alu_op_id_ex,
    input  logic              alu_a_sel_id_ex,
    input  logic              alu_b_sel_id_ex,
    input  logic [3:0]        md_op_id_ex,
    input  logic [WIDTH-1:0]  imm_id_ex,
    input  logic              mem_en_id_ex,
    input  logic              rd_en_id_ex,
    input  logic [ADDR_W-1:0] rd_addr_id_ex,
    input  logic              rd_data_sel_id_ex,
    input  logic [WIDTH-1:0]  rs_data_id_ex,
    input  logic [WIDTH-1:0]  rt_data_id_ex,
    input  logic              stall_mem,
    input  logic              flush,
    output logic              stall_ex,
    output logic              valid_ex_mem,
    output logic [WIDTH-1:0]  alu_data_ex_mem,
    output logic              rd_en_ex_mem,
    output logic [ADDR_W-1:0] rd_addr_ex_mem,
    output logic              rd_data_sel_ex_mem,
    output logic [WIDTH-1:0]  rt_data_ex_mem,
    output logic              mem_en_ex_mem,
    output logic              md_busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} md_state_t;

    md_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo, p_hi, p_lo, opb, dvd;
    logic               is_div, neg_lo, neg_hi, div_zero;

    logic               hazard, accept, md_start, md_signed, rs_neg, rt_neg, no_wb;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_y, result, rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign hazard   = valid_id_ex & md_busy & (md_op_id_ex != 4'd0);
    assign stall_ex = stall_mem | hazard;
    assign accept   = valid_id_ex & ~flush & ~stall_ex;
    assign md_busy  = (state != S_IDLE);

    assign md_start  = accept & (md_op_id_ex >= MD_MULT) & (md_op_id_ex <= MD_DIVU);
    assign md_signed = (md_op_id_ex == MD_MULT) | (md_op_id_ex == MD_DIV);
    assign rs_neg    = md_signed & rs_data_id_ex[WIDTH-1];
    assign rt_neg    = md_signed & rt_data_id_ex[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_data_id_ex : rs_data_id_ex;
    assign rt_mag    = rt_neg ? -rt_data_id_ex : rt_data_id_ex;

    // Instructions that only touch HI/LO or start the MD unit never write the register file.
    assign no_wb = ((md_op_id_ex >= MD_MULT) & (md_op_id_ex <= MD_DIVU))
                 | (md_op_id_ex == MD_MTHI) | (md_op_id_ex == MD_MTLO);

    assign alu_a = alu_a_sel_id_ex
                 ? {{(WIDTH-SHAMT_W){1'b0}}, imm_id_ex[SHAMT_W+5:6]}
                 : rs_data_id_ex;
    assign alu_b = alu_b_sel_id_ex ? imm_id_ex : rt_data_id_ex;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op (alu_op_id_ex),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign result = (md_op_id_ex == MD_MFHI) ? hi :
                    (md_op_id_ex == MD_MFLO) ? lo : alu_y;

    // Shift-add: p_lo holds the unused multiplier bits, p_hi accumulates the product top.
    assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
    // Restoring divide: p_hi is the partial remainder, p_lo shifts dividend out / quotient in.
    assign div_sh   = {p_hi, p_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb};
    assign prod     = {p_hi, p_lo};
    assign prod_fix = neg_lo ? -prod : prod;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (md_start) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            opb      <= '0;
            dvd      <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        p_hi     <= '0;
                        p_lo     <= rs_mag;
                        opb      <= rt_mag;
                        dvd      <= rs_data_id_ex;
                        cnt      <= CNT_W'(WIDTH-1);
                        is_div   <= (md_op_id_ex >= MD_DIV);
                        neg_lo   <= rs_neg ^ rt_neg;
                        neg_hi   <= rs_neg;
                        div_zero <= (rt_data_id_ex == '0);
                    end else if (accept && md_op_id_ex == MD_MTHI) begin
                        hi <= rs_data_id_ex;
                    end else if (accept && md_op_id_ex == MD_MTLO) begin
                        lo <= rs_data_id_ex;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            p_hi <= div_diff[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            p_hi <= div_sh[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        lo <= '1;
                        hi <= dvd;
                    end else begin
                        lo <= neg_lo ? -p_lo : p_lo;
                        hi <= neg_hi ? -p_hi : p_hi;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_ex_mem       <= 1'b0;
            alu_data_ex_mem    <= '0;
            rd_en_ex_mem       <= 1'b0;
            rd_addr_ex_mem     <= '0;
            rd_data_sel_ex_mem <= 1'b0;
            rt_data_ex_mem     <= '0;
            mem_en_ex_mem      <= 1'b0;
        end else if (!stall_mem) begin
            valid_ex_mem       <= accept;
            alu_data_ex_mem    <= result;
            rd_en_ex_mem       <= accept & rd_en_id_ex & ~no_wb;
            rd_addr_ex_mem     <= rd_addr_id_ex;
            rd_data_sel_ex_mem <= rd_data_sel_id_ex;
            rt_data_ex_mem     <= rt_data_id_ex;
            mem_en_ex_mem      <= accept & mem_en_id_ex;
        end
    end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised EX stage: single-cycle ALU path plus an iterative multiply/divide unit with HI/LO registers.
- Adds valid/stall/flush pipeline control and MD-hazard interlock.
- Sits between decode (id_ex) and memory (ex_mem).
- Reuses the existing alu module for the combinational ALU path.

Parameters:
- WIDTH, 32, datapath width (even, >=8).
- ADDR_W, 5, register-file address width.
- SHAMT_W, 5, shift-amount width, taken from imm_id_ex[SHAMT_W+5:6].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_id_ex  in  1  instruction present in EX
- alu_op_id_ex  in  4  ALU opcode
- alu_a_sel_id_ex  in  1  1 = zero-extended shamt, 0 = rs
- alu_b_sel_id_ex  in  1  1 = imm, 0 = rt
- md_op_id_ex  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
- imm_id_ex  in  WIDTH  sign-extended immediate
- mem_en_id_ex  in  1  memory access
- rd_en_id_ex  in  1  register writeback enable
- rd_addr_id_ex  in  ADDR_W  destination register
- rd_data_sel_id_ex  in  1  writeback source select
- rs_data_id_ex  in  WIDTH  rs operand
- rt_data_id_ex  in  WIDTH  rt operand
- stall_mem  in  1  downstream stall
- flush  in  1  kill the instruction in EX
- stall_ex  out  1  EX cannot accept; upstream holds
- valid_ex_mem  out  1  pipeline valid
- alu_data_ex_mem  out  WIDTH  result
- rd_en_ex_mem  out  1  writeback enable
- rd_addr_ex_mem  out  ADDR_W  destination register
- rd_data_sel_ex_mem  out  1  writeback source select
- rt_data_ex_mem  out  WIDTH  store data
- mem_en_ex_mem  out  1  memory access
- md_busy  out  1  MD unit not idle

Behaviour:
- Reset:
  - All ex_mem outputs 0.
  - HI = LO = 0.
  - FSM to IDLE; md_busy = 0; stall_ex = 0.
  - Reset mid-operation aborts the MD op; HI/LO are not updated.
- hazard = valid_id_ex & md_busy & (md_op_id_ex != 0).
- stall_ex = stall_mem | hazard.
- accept = valid_id_ex & ~flush & ~stall_ex.
- stall_mem = 1: all ex_mem registers hold, including valid. No MD op starts.
- Otherwise, each cycle:
  - ex_mem captures the instruction.
  - valid_ex_mem <= accept.
  - If ~accept: valid, rd_en and mem_en load 0 (bubble); data fields are don't-care.
- Flush: the instruction is squashed as a bubble and no MD op starts. An MD op already running continues to completion. Flush with stall_mem = 1 has no effect; decode holds flush until released.
- ALU path:
  - Result is registered 1 cycle after accept.
  - md_op = 0 selects the alu result.
  - MFHI/MFLO select HI/LO instead of the ALU result.
- MTHI/MTLO write HI/LO from rs on accept; their rd_en is forced 0.
- MULT/MULTU/DIV/DIVU:
  - On accept, latch operands and enter BUSY.
  - The instruction itself retires to ex_mem with rd_en forced 0.
- FSM:
  - IDLE -> BUSY on MD start.
  - BUSY runs exactly WIDTH cycles: one shift-add or restoring-subtract step per cycle; counter WIDTH-1 down to 0.
  - BUSY -> FIX.
  - FIX: 1 cycle. Apply sign correction and write HI/LO.
  - FIX -> IDLE.
  - md_busy = (state != IDLE), i.e. WIDTH+1 cycles per op.
- Signed ops operate on magnitudes, then negate:
  - Product: negated if the operand signs differ.
  - Quotient: negated if the signs differ.
  - Remainder: takes the sign of the dividend.
- MULT/MULTU: HI:LO = 2*WIDTH-bit product.
- DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend; no trap.
- Signed overflow (-2^(WIDTH-1) / -1): LO = -2^(WIDTH-1), HI = 0.
- Any MD-class op arriving while md_busy stalls until IDLE. A MFLO issued the cycle after MULT stalls exactly WIDTH+1 cycles, then is accepted.
- Non-MD instructions are never stalled by md_busy.

Test Plan:
- ADD path (alu_op add): rs = 5, rt = 7, accepted at cycle N -> cycle N+1: valid_ex_mem = 1, alu_data = 12, rd_addr and flags passed through.
- MULT 7 x -3, then MFLO and MFHI back-to-back:
  - stall_ex high for 33 cycles.
  - MFLO result 0xFFFFFFEB; MFHI result 0xFFFFFFFF; rd_en = 1.
  - MULT instruction itself retires with rd_en = 0.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 0x10 / 0 -> LO = 0xFFFFFFFF, HI = 0x10.
- Signed overflow: DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- stall_mem held 3 cycles while a valid ADD is in EX:
  - ex_mem outputs frozen.
  - flush asserted during the stall has no effect.
  - After release the ADD is captured once.
  - flush in a non-stalled cycle -> valid_ex_mem = 0, rd_en = 0.
- rst asserted 10 cycles into a MULT:
  - Next cycle: md_busy = 0, HI/LO = 0, all outputs 0.
  - A following MFHI returns 0 without stalling.
